// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM port, hazard/redirect controls and the IF/ID register outputs.
// The master side drives the controls and ROM data; the slave side is the fetch stage.
interface fetch_stage_if #(
   parameter int PC_W = 64
);
   logic [15:0]     rom_address;
   logic [31:0]     rom_data;
   logic            stall;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] ifid_pc;
   logic [31:0]     ifid_instr;
   logic            ifid_valid;
   logic            fetch_done;

   modport master (
      output rom_data, stall, branch_taken, branch_target,
      input  rom_address, ifid_pc, ifid_instr, ifid_valid, fetch_done
   );

   modport slave (
      input  rom_data, stall, branch_taken, branch_target,
      output rom_address, ifid_pc, ifid_instr, ifid_valid, fetch_done
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and fills IF/ID.
// Priority per edge: redirect/flush > stall > halt-at-end-of-program > normal fetch.
module fetch_stage #(
   parameter int PC_W       = 64,
   parameter int PROG_WORDS = 4
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));
   localparam logic [PC_W-3:0] DONE_WORD  = (PC_W-2)'(PROG_WORDS);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            fetch_done;

   assign fetch_done      = (pc_q[PC_W-1:2] >= DONE_WORD);
   assign bus.rom_address = pc_q[17:2];
   assign bus.fetch_done  = fetch_done;
   assign bus.ifid_pc     = ifid_pc_q;
   assign bus.ifid_instr  = ifid_instr_q;
   assign bus.ifid_valid  = ifid_valid_q;

   // NOTE: every next-state signal gets a hold default first so no path leaves it
   // unassigned (no inferred latch); combinational logic uses blocking '='.
   always_comb begin
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      if (bus.branch_taken) begin
         // Target low bits are dropped so the PC stays word aligned.
         pc_d         = bus.branch_target & ALIGN_MASK;
         ifid_pc_d    = '0;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (fetch_done) begin
         ifid_pc_d    = '0;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
      end else begin
         ifid_pc_d    = pc_q;
         ifid_instr_d = bus.rom_data;
         ifid_valid_d = 1'b1;
         pc_d         = pc_q + PC_W'(4);
      end
   end

   // NOTE: registers update with non-blocking '<=' so all flops see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= '0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued as each step is driven
// and popped for comparison one edge later.
module tb_fetch_stage;
   localparam int PC_W = 64;

   typedef struct {
      string       tag;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic [15:0] rom_addr;
      logic        done;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;
   exp_t sb[$];

   fetch_stage_if #(.PC_W(PC_W)) bus ();

   fetch_stage #(.PC_W(PC_W), .PROG_WORDS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction ROM holding the 4-word test program.
   always_comb begin
      case (bus.rom_address)
         16'd0:   bus.rom_data = 32'hF8400081;
         16'd1:   bus.rom_data = 32'h8B020023;
         16'd2:   bus.rom_data = 32'hF8401082;
         16'd3:   bus.rom_data = 32'h8B020023;
         default: bus.rom_data = 32'hFFFF_FFFF;
      endcase
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input exp_t e);
      n_checks++;
      assert (bus.ifid_pc === e.pc) else begin
         n_fails++;
         $error("FAIL %s ifid_pc: got %0h expected %0h", e.tag, bus.ifid_pc, e.pc);
      end
      n_checks++;
      assert (bus.ifid_instr === e.instr) else begin
         n_fails++;
         $error("FAIL %s ifid_instr: got %08h expected %08h", e.tag, bus.ifid_instr, e.instr);
      end
      n_checks++;
      assert (bus.ifid_valid === e.valid) else begin
         n_fails++;
         $error("FAIL %s ifid_valid: got %0b expected %0b", e.tag, bus.ifid_valid, e.valid);
      end
      n_checks++;
      assert (bus.rom_address === e.rom_addr) else begin
         n_fails++;
         $error("FAIL %s rom_address: got %0d expected %0d", e.tag, bus.rom_address, e.rom_addr);
      end
      n_checks++;
      assert (bus.fetch_done === e.done) else begin
         n_fails++;
         $error("FAIL %s fetch_done: got %0b expected %0b", e.tag, bus.fetch_done, e.done);
      end
   endtask

   // Drive one cycle of controls, queue the expected post-edge state, then compare after the edge.
   task automatic step(input string tag, input logic st, input logic br, input logic [63:0] tgt,
                       input logic [63:0] e_pc, input logic [31:0] e_instr, input logic e_valid,
                       input logic [15:0] e_addr, input logic e_done);
      exp_t e;
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      e = '{tag, e_pc, e_instr, e_valid, e_addr, e_done};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fails++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         check(sb.pop_front());
      end
   endtask

   initial begin
      n_checks          = 0;
      n_fails           = 0;
      reset             = 1'b1;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      #12;
      check('{"reset", 64'd0, 32'h0, 1'b0, 16'd0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      #1;

      // Free-run through the program, then halt with bubbles.
      step("run0",  0, 0, 0, 64'd0,  32'hF8400081, 1, 16'd1, 0);
      step("run1",  0, 0, 0, 64'd4,  32'h8B020023, 1, 16'd2, 0);
      step("run2",  0, 0, 0, 64'd8,  32'hF8401082, 1, 16'd3, 0);
      step("run3",  0, 0, 0, 64'd12, 32'h8B020023, 1, 16'd4, 1);
      step("halt0", 0, 0, 0, 64'd0,  32'h0,        0, 16'd4, 1);
      step("halt1", 0, 0, 0, 64'd0,  32'h0,        0, 16'd4, 1);

      // Redirect out of the halted state back to word 0.
      step("rst_br", 0, 1, 64'd0, 64'd0, 32'h0,        0, 16'd0, 0);
      step("re0",    0, 0, 0,     64'd0, 32'hF8400081, 1, 16'd1, 0);
      step("re1",    0, 0, 0,     64'd4, 32'h8B020023, 1, 16'd2, 0);

      // Stall for two cycles while IF/ID holds pc 4.
      step("stall0", 1, 0, 0, 64'd4, 32'h8B020023, 1, 16'd2, 0);
      step("stall1", 1, 0, 0, 64'd4, 32'h8B020023, 1, 16'd2, 0);
      step("unstl",  0, 0, 0, 64'd8, 32'hF8401082, 1, 16'd3, 0);

      // Misaligned redirect target 0x5 from pc 12 lands on pc 4.
      step("br5",    0, 1, 64'h5, 64'd0, 32'h0,        0, 16'd1, 0);
      step("br5_t",  0, 0, 0,     64'd4, 32'h8B020023, 1, 16'd2, 0);

      // Flush wins over a simultaneous stall.
      step("brstl",  1, 1, 64'hC, 64'd0,  32'h0,        0, 16'd3, 0);
      step("brstl_t",0, 0, 0,     64'd12, 32'h8B020023, 1, 16'd4, 1);

      // Set up pc 8 under stall, then reset asynchronously mid-cycle.
      step("br4",    0, 1, 64'h4, 64'd0, 32'h0,        0, 16'd1, 0);
      step("br4_t",  0, 0, 0,     64'd4, 32'h8B020023, 1, 16'd2, 0);
      step("stl8",   1, 0, 0,     64'd4, 32'h8B020023, 1, 16'd2, 0);
      #2;
      reset = 1'b1;
      #1;
      check('{"async_rst", 64'd0, 32'h0, 1'b0, 16'd0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      #1;
      step("post_rst", 0, 0, 0, 64'd0, 32'hF8400081, 1, 16'd1, 0);

      n_checks++;
      assert (sb.size() == 0) else begin
         n_fails++;
         $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
